// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state encodings for the fetch sequencer.
package fetch_pkg;

    localparam int unsigned BYTES_PER_WORD  = 4;
    localparam logic [7:0]  NUL_CHAR        = 8'h00;

    // Upper bound on MAX_WORDS; sizes the word counter and the WORD_CNT port.
    localparam int unsigned MAX_WORDS_LIMIT = 4096;
    localparam int unsigned WORD_CNT_WIDTH  = $clog2(MAX_WORDS_LIMIT) + 1;

    // Sequencer state encodings (kept as plain constants for legacy tools).
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] UNPACK = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] DRAIN  = 3'd5;

endpackage

// File: rtl/fetch_seq_word_unpack.sv
// word_unpack: holds one fetched word and presents it byte by byte,
// little-endian, flagging NUL bytes and the last byte of the word.
module word_unpack
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    output logic [7:0]            byte_out_o,
    output logic                  is_nul_o,
    output logic                  last_o
);

    logic [DATA_WIDTH-1:0] word_q;
    logic [1:0]            idx_q;

    // Word buffer and byte index: load restarts at byte 0, advance steps on.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            idx_q  <= '0;
        end else if (advance_i) begin
            idx_q  <= idx_q + 2'd1;
        end
    end

    // Byte mux and per-byte flags.
    always_comb begin
        byte_out_o = word_q[{idx_q, 3'b000} +: 8];
        is_nul_o   = (byte_out_o == NUL_CHAR);
        last_o     = (idx_q == 2'(BYTES_PER_WORD - 1));
    end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: fetches a NUL-terminated byte stream from word memory and
// pushes it, one byte per handshake, into the lexer FIFO.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WORDS  = 4096
) (
    input  logic                      CCLK,
    input  logic                      CRST,
    input  logic                      CEXEC,
    input  logic [ADDR_WIDTH-1:0]     START_ADDR,
    output logic [ADDR_WIDTH-1:0]     I_ADDR,
    output logic                      I_VALID,
    input  logic                      MEM_WAIT,
    input  logic                      O_VALID,
    input  logic [DATA_WIDTH-1:0]     O_DATA,
    output logic                      BYTE_VALID,
    output logic [7:0]                BYTE_DATA,
    input  logic                      BYTE_READY,
    output logic                      CSTAT,
    output logic [WORD_CNT_WIDTH-1:0] WORD_CNT
);

    localparam logic [WORD_CNT_WIDTH-1:0] WCNT_LIMIT = WORD_CNT_WIDTH'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0]     ALIGN_MASK = ~ADDR_WIDTH'(BYTES_PER_WORD - 1);

    logic [2:0]                state_q, state_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [WORD_CNT_WIDTH-1:0] wcnt_q, wcnt_d, wcnt_inc;

    logic       accept;
    logic       load, advance;
    logic       is_nul, last;
    logic [7:0] cur_byte;

    word_unpack #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_unpack (
        .clk_i      (CCLK),
        .rst_i      (CRST),
        .load_i     (load),
        .advance_i  (advance),
        .word_i     (O_DATA),
        .byte_out_o (cur_byte),
        .is_nul_o   (is_nul),
        .last_o     (last)
    );

    assign accept   = (state_q == REQ) && !MEM_WAIT;
    assign wcnt_inc = wcnt_q + WORD_CNT_WIDTH'(1);

    // Next-state logic: run sequencing, abort handling and word counting.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        wcnt_d  = wcnt_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (CEXEC) begin
                    base_d  = START_ADDR & ALIGN_MASK;
                    wcnt_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // An accepted request always owes one response, so an abort
                // on the accepting cycle must still drain it.
                if (accept) begin
                    state_d = CEXEC ? WAIT : DRAIN;
                end else if (!CEXEC) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!CEXEC) begin
                    state_d = O_VALID ? IDLE : DRAIN;
                end else if (O_VALID) begin
                    load    = 1'b1;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                if (!CEXEC) begin
                    state_d = IDLE;
                end else if (is_nul) begin
                    state_d = DONE;
                end else if (BYTE_READY) begin
                    if (last) begin
                        wcnt_d  = wcnt_inc;
                        state_d = (wcnt_inc == WCNT_LIMIT) ? DONE : REQ;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!CEXEC) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (O_VALID) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // IDLE presents reset-like outputs, including a zero word count.
        if (state_d == IDLE) begin
            wcnt_d = '0;
        end
    end

    // State, base address and word counter registers.
    always_ff @(posedge CCLK) begin
        if (CRST) begin
            state_q <= IDLE;
            base_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Outputs decoded from the registered state; address wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        I_VALID    = (state_q == REQ);
        I_ADDR     = I_VALID ? (base_q + ADDR_WIDTH'({wcnt_q, 2'b00})) : '0;
        BYTE_VALID = (state_q == UNPACK) && !is_nul;
        BYTE_DATA  = BYTE_VALID ? cur_byte : '0;
        CSTAT      = (state_q == DONE);
        WORD_CNT   = wcnt_q;
    end

endmodule
